multiplier_shift_add_unsigned: RTL and testbench

Sequential shift-and-add unsigned integer multiplier: the inverse-operation companion to the team's restoring divider, sharing its start/done handshake, CE gating and working-register style. Sits beside the divider in arithmetic datapaths where area matters more than latency. It consumes one multiplier bit per iteration and produces a full-width, never-truncated product.

---
 rtl/multiplier_shift_add_unsigned_pkg.sv | 23 ++
 rtl/multiplier_shift_add_unsigned.sv | 168 ++++++++++++++++
 tb/tb_multiplier_shift_add_unsigned.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_shift_add_unsigned_pkg.sv
`default_nettype none
// ============================================================================
// Package    : mult_pkg
// Purpose    : Shared types for the shift-and-add multiplier family. The state
//              enum is common to all multiplier variants so that debug views
//              and future variants decode states identically.
// Contents   : mult_state_t  - FSM state encoding (2 bits)
//              MULT_STATE_W  - width of mult_state_t
// Revision   : 1.0 - initial release
// ============================================================================
package mult_pkg;

  localparam int MULT_STATE_W = 2;

  typedef enum logic [MULT_STATE_W-1:0] {
    S_IDLE   = 2'd0,
    S_ADD    = 2'd1,
    S_SHIFT  = 2'd2,
    S_OUTPUT = 2'd3
  } mult_state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/multiplier_shift_add_unsigned.sv
`default_nettype none
// ============================================================================
// Module     : multiplier_shift_add_unsigned
// Purpose    : Sequential shift-and-add unsigned multiplier. Consumes one
//              multiplier bit per iteration and produces the full-width
//              product A*B. Start/done handshake with clock-enable gating.
// Parameters : MUL_A_BITS - multiplicand width (>=2)
//              MUL_B_BITS - multiplier width (>=2), also the iteration count
// Ports      : CLK             in   clock, rising edge
//              SRST_N          in   synchronous reset, active-low
//              CE              in   clock enable; low holds everything
//              MULTIPLICAND_IN in   operand A, sampled on accepted start
//              MULTIPLIER_IN   in   operand B, sampled on accepted start
//              PRODUCT_OUT     out  registered A*B, held until next result
//              start           in   request, accepted only when idle
//              busy            out  high while an operation is in flight
//              done            out  one CE-cycle pulse on PRODUCT_OUT update
// Options    : MULT_SKIP_ZERO_EN - when defined, the add state is skipped
//              for multiplier bits that are 0 (operand-dependent latency).
// Revision   : 1.0 - initial release
// ============================================================================
module multiplier_shift_add_unsigned
  import mult_pkg::*;
#(
  parameter int MUL_A_BITS = 8,
  parameter int MUL_B_BITS = 8
) (
  input  logic                           CLK,
  input  logic                           SRST_N,
  input  logic                           CE,
  input  logic [MUL_A_BITS-1:0]          MULTIPLICAND_IN,
  input  logic [MUL_B_BITS-1:0]          MULTIPLIER_IN,
  output logic [MUL_A_BITS+MUL_B_BITS-1:0] PRODUCT_OUT,
  input  logic                           start,
  output logic                           busy,
  output logic                           done
);

  localparam int P_BITS   = MUL_A_BITS + MUL_B_BITS;
  // One extra bit above the product holds the carry out of each add.
  localparam int ACC_BITS = P_BITS + 1;
  localparam int CNT_BITS = $clog2(MUL_B_BITS);
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(MUL_B_BITS - 1);

  mult_state_t             state_q;
  mult_state_t             state_d;
  logic [ACC_BITS-1:0]     acc_q;
  logic [MUL_A_BITS-1:0]   mcand_q;
  logic [CNT_BITS-1:0]     cnt_q;
  logic [P_BITS-1:0]       product_q;
  logic                    done_q;

  // --------------------------------------------------------------------------
  // State register: reset wins over CE.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!SRST_N) begin
      state_q <= S_IDLE;
    end else if (CE) begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef MULT_SKIP_ZERO_EN
          // First multiplier bit decides whether an add is needed at all.
          state_d = MULTIPLIER_IN[0] ? S_ADD : S_SHIFT;
`else
          state_d = S_ADD;
`endif
        end
      end
      S_ADD: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = S_OUTPUT;
        end else begin
`ifdef MULT_SKIP_ZERO_EN
          // acc_q[1] is the bit that lands in acc[0] after this shift.
          state_d = acc_q[1] ? S_ADD : S_SHIFT;
`else
          state_d = S_ADD;
`endif
        end
      end
      S_OUTPUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Working registers (not reset: a fresh start always reloads them).
  // Upper field acc[P_BITS:MUL_B_BITS] accumulates partial products; the
  // lower field starts as the multiplier and is consumed from bit 0 while
  // product bits shift in from above.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (CE) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q   <= {{(MUL_A_BITS + 1){1'b0}}, MULTIPLIER_IN};
            mcand_q <= MULTIPLICAND_IN;
            cnt_q   <= CNT_INIT;
          end
        end
        S_ADD: begin
          if (acc_q[0]) begin
            acc_q[P_BITS:MUL_B_BITS] <= acc_q[P_BITS:MUL_B_BITS] + {1'b0, mcand_q};
          end
        end
        S_SHIFT: begin
          acc_q <= acc_q >> 1;
          cnt_q <= cnt_q - CNT_BITS'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Result and done registers. The carry bit is always 0 after the final
  // shift, so only the low P_BITS are published.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!SRST_N) begin
      product_q <= '0;
      done_q    <= 1'b0;
    end else if (CE) begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
        end
        S_OUTPUT: begin
          product_q <= acc_q[P_BITS-1:0];
          done_q    <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs.
  // --------------------------------------------------------------------------
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = done_q;
    PRODUCT_OUT = product_q;
  end

endmodule : multiplier_shift_add_unsigned
`default_nettype wire

// File: tb/tb_multiplier_shift_add_unsigned.sv
`default_nettype none
// ============================================================================
// Module     : tb_multiplier_shift_add_unsigned
// Purpose    : Self-checking bench for multiplier_shift_add_unsigned with
//              8x8 operands. A cycle-level behavioural model (countdown of
//              CE-enabled edges, product by plain multiplication) is compared
//              against busy/done/PRODUCT_OUT on every falling edge; directed
//              cases additionally pin literal products and latencies.
// Options    : MULT_SKIP_ZERO_EN - selects the operand-dependent latency rule.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_multiplier_shift_add_unsigned;

`ifdef MULT_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int B_BITS = 8;

  logic        clk = 1'b0;
  logic        SRST_N;
  logic        CE;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic [15:0] PRODUCT_OUT;
  logic        start;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiplier_shift_add_unsigned #(
    .MUL_A_BITS(8),
    .MUL_B_BITS(8)
  ) dut (
    .CLK            (clk),
    .SRST_N         (SRST_N),
    .CE             (CE),
    .MULTIPLICAND_IN(a_in),
    .MULTIPLIER_IN  (b_in),
    .PRODUCT_OUT    (PRODUCT_OUT),
    .start          (start),
    .busy           (busy),
    .done           (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Edges from accepted start to done, counted in CE-enabled edges.
  function automatic int lat_of(input logic [7:0] b);
    if (SKIP) return B_BITS + $countones(b) + 1;
    else      return 2 * B_BITS + 1;
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_done  = 1'b0;
  logic [15:0] m_prod  = '0;
  logic [7:0]  m_a, m_b;
  int          m_rem   = 0;

  always @(posedge clk) begin
    if (!SRST_N) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_prod  = '0;
    end else if (CE) begin
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_prod = {8'b0, m_a} * {8'b0, m_b};
        end
      end else begin
        m_done = 1'b0;
        if (start) begin
          m_a    = a_in;
          m_b    = b_in;
          m_rem  = lat_of(b_in);
          m_busy = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("product", {16'b0, PRODUCT_OUT}, {16'b0, m_prod});
    end
  end

  // Entered and left at posedge+1. Optionally randomises CE during the
  // operation, or hammers start with other operands while busy.
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b,
                        input int exp_p, input int exp_lat,
                        input bit ce_rand, input bit interfere);
    int  edges;
    int  lows;
    logic ce_e;
    CE    = 1'b1;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 0;
    lows  = 0;
    while (1) begin
      if (ce_rand) CE = 1'($urandom_range(0, 1));
      if (interfere) begin
        start = 1'b1;
        a_in  = 8'($urandom_range(0, 255));
        b_in  = 8'($urandom_range(0, 255));
      end
      ce_e = CE;
      @(posedge clk);
      edges++;
      if (!ce_e) lows++;
      #1;
      if (done) break;
      if (edges > 400) begin
        chk("done_timeout", 32'(edges), 32'(exp_lat + lows));
        break;
      end
    end
    start = 1'b0;
    CE    = 1'b1;
    chk("product_lit", {16'b0, PRODUCT_OUT}, 32'(exp_p));
    chk("latency", 32'(edges), 32'(exp_lat + lows));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    SRST_N = 1'b0;
    CE     = 1'b1;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    SRST_N = 1'b1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_product", {16'b0, PRODUCT_OUT}, 32'd0);

    // Directed cases with literal products and latencies.
    do_mul(8'd13,  8'd11,  143,   SKIP ? 12 : 17, 1'b0, 1'b0);
    do_mul(8'd255, 8'd255, 65025, 17,             1'b0, 1'b0);
    do_mul(8'd200, 8'd0,   0,     SKIP ? 9 : 17,  1'b0, 1'b0);
    do_mul(8'd0,   8'h81,  0,     SKIP ? 11 : 17, 1'b0, 1'b0);
    // start while busy is ignored; then a start on the done cycle.
    do_mul(8'd100, 8'd77,  7700,  SKIP ? 13 : 17, 1'b0, 1'b1);
    do_mul(8'd3,   8'd5,   15,    SKIP ? 11 : 17, 1'b0, 1'b0);
    // Random CE stalls stretch latency by the number of CE-low edges.
    do_mul(8'd45,  8'd210, 9450,  SKIP ? 13 : 17, 1'b1, 1'b0);

    // Reset mid-operation aborts without a done pulse.
    repeat (2) begin @(posedge clk); #1; end
    a_in  = 8'd200;
    b_in  = 8'd123;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    SRST_N = 1'b0;
    @(posedge clk);
    #1;
    SRST_N = 1'b1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_product", {16'b0, PRODUCT_OUT}, 32'd0);
    repeat (20) begin @(posedge clk); #1; end
    chk("abort_no_done", {31'b0, done}, 32'd0);
    do_mul(8'd7, 8'd9, 63, SKIP ? 11 : 17, 1'b0, 1'b0);

    // Randomised operands, gaps and CE stalls.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 5))
        0:       rb = 8'h00;
        1:       rb = 8'hFF;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      do_mul(ra, rb, int'(ra) * int'(rb), lat_of(rb), (i % 3) == 0, (i % 7) == 3);
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_multiplier_shift_add_unsigned
`default_nettype wire
